// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed common-anode 7-segment scanner with frame snapshots and field blink.
// Optional: LEADING_ZERO_BLANK_EN blanks slot 3 when the minutes_top snapshot is zero.
module seven_seg_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] minutes_top_digit,
  input  logic [3:0] minutes_bot_digit,
  input  logic [3:0] seconds_top_digit,
  input  logic [3:0] seconds_bot_digit,
  input  logic       adj,
  input  logic       sel,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

  logic [RW-1:0]     refresh_cnt_q, refresh_cnt_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0][3:0]   snap_q, snap_d;
  logic [6:0]        seg_q, seg_d;
  logic [3:0]        an_q, an_d;
  logic              dp_q, dp_d;

  logic              refresh_term;
  logic              blink_term;
  logic [3:0]        digit;
  logic [6:0]        seg_dec;
  logic              blank;

  always_comb begin
    refresh_term  = (refresh_cnt_q == R_LAST);
    refresh_cnt_d = refresh_term ? '0 : refresh_cnt_q + 1'b1;
    idx_d         = refresh_term ? idx_q + 2'd1 : idx_q;

    // Snapshot only at the frame boundary so a frame is always coherent
    snap_d = snap_q;
    if (refresh_term && (idx_q == 2'd3)) begin
      snap_d = {minutes_top_digit, minutes_bot_digit,
                seconds_top_digit, seconds_bot_digit};
    end

    blink_term    = (blink_cnt_q == B_LAST);
    blink_cnt_d   = blink_term ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = blink_term ? ~blink_phase_q : blink_phase_q;

    digit = snap_q[idx_q];
    case (digit)
      4'd0:    seg_dec = 7'h40;
      4'd1:    seg_dec = 7'h79;
      4'd2:    seg_dec = 7'h24;
      4'd3:    seg_dec = 7'h30;
      4'd4:    seg_dec = 7'h19;
      4'd5:    seg_dec = 7'h12;
      4'd6:    seg_dec = 7'h02;
      4'd7:    seg_dec = 7'h78;
      4'd8:    seg_dec = 7'h00;
      4'd9:    seg_dec = 7'h10;
      default: seg_dec = 7'h7F;
    endcase

    // sel=1 picks the seconds pair (idx 0,1), sel=0 the minutes pair
    blank = adj && blink_phase_q && (sel ? ~idx_q[1] : idx_q[1]);
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx_q == 2'd3) && (snap_q[3] == 4'd0)) begin
      blank = 1'b1;
    end
`else
`endif

    an_d  = blank ? 4'hF : ~(4'b0001 << idx_q);
    seg_d = blank ? 7'h7F : seg_dec;
    dp_d  = ~((idx_q == 2'd2) && !blank);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt_q <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      idx_q         <= 2'd0;
      snap_q        <= '0;
      seg_q         <= 7'h7F;
      an_q          <= 4'hF;
      dp_q          <= 1'b1;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      idx_q         <= idx_d;
      snap_q        <= snap_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      dp_q          <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan with REFRESH_DIV=4, BLINK_DIV=16.
// Expected display words are queued before each edge and checked just after it.
module tb_seven_seg_scan;

  localparam int RD = 4;
  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] dig [4];
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          k        = 0;
  logic [3:0]  shown [4];
  logic [11:0] exp_q [$];

  seven_seg_scan #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .clk(clk),
    .rst(rst),
    .minutes_top_digit(dig[3]),
    .minutes_bot_digit(dig[2]),
    .seconds_top_digit(dig[1]),
    .seconds_bot_digit(dig[0]),
    .adj(adj),
    .sel(sel),
    .seg(seg),
    .dp(dp),
    .an(an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Output for cycle k: slot = k/RD, frame = k/(4*RD), blink half-period = k/BD
  function automatic logic [11:0] expect_now();
    int   slot;
    bit   ph;
    bit   blank;
    logic [3:0] a;
    if (rst) return {4'hF, 7'h7F, 1'b1};
    slot  = (k / RD) % 4;
    ph    = ((k / BD) % 2) == 1;
    blank = adj && ph && (sel ? (slot < 2) : (slot >= 2));
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 3 && shown[3] == 4'd0) blank = 1;
`endif
    if (blank) return {4'hF, 7'h7F, 1'b1};
    a = 4'hF;
    a[slot] = 1'b0;
    return {a, dec(shown[slot]), (slot == 2) ? 1'b0 : 1'b1};
  endfunction

  task automatic tick();
    exp_q.push_back(expect_now());
    @(posedge clk);
    if (rst) begin
      k = 0;
      for (int i = 0; i < 4; i++) shown[i] = 4'd0;
    end else begin
      if (k % (4 * RD) == 4 * RD - 1) begin
        for (int i = 0; i < 4; i++) shown[i] = dig[i];
      end
      k++;
    end
    #1;
  endtask

  task automatic set_dig(input logic [3:0] mt, input logic [3:0] mb,
                         input logic [3:0] st, input logic [3:0] sb);
    dig[3] = mt;
    dig[2] = mb;
    dig[1] = st;
    dig[0] = sb;
  endtask

  task automatic test_reset();
    logic [11:0] e;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({an, seg, dp} !== e || e !== 12'hFFF) begin
        n_fail++;
        $display("FAIL reset k=%0d got an=%h seg=%h dp=%b exp an=F seg=7F dp=1",
                 k, an, seg, dp);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_frames(input string name, input int n);
    logic [11:0] e;
    for (int i = 0; i < n; i++) begin
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({an, seg, dp} !== e) begin
        n_fail++;
        $display("FAIL %s k=%0d got an=%h seg=%h dp=%b exp an=%h seg=%h dp=%b",
                 name, k, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
    end
  endtask

  task automatic test_mid_frame_change();
    logic [11:0] e;
    for (int i = 0; i < 4 * RD; i++) begin
      if (i == RD + 1) set_dig(4'd5, 4'd6, 4'd7, 4'd8);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({an, seg, dp} !== e) begin
        n_fail++;
        $display("FAIL mid_change k=%0d got an=%h seg=%h dp=%b exp an=%h seg=%h dp=%b",
                 k, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [11:0] e;
    int guard;
    guard = 0;
    while ((k % (4 * RD)) != 2 * RD + 1 && guard < 64) begin
      tick();
      guard++;
      e = exp_q.pop_front();
      n_checks++;
      if ({an, seg, dp} !== e) begin
        n_fail++;
        $display("FAIL pre_reset k=%0d got an=%h seg=%h dp=%b exp an=%h seg=%h dp=%b",
                 k, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if ({an, seg, dp} !== e || e !== 12'hFFF) begin
      n_fail++;
      $display("FAIL mid_reset got an=%h seg=%h dp=%b exp an=F seg=7F dp=1",
               an, seg, dp);
    end
  endtask

  initial begin
    set_dig(4'd0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 4; i++) shown[i] = 4'd0;
    test_reset();
    set_dig(4'd1, 4'd2, 4'd3, 4'd4);
    test_frames("first_frame", 4 * RD);
    test_frames("steady", 4 * RD);
    test_mid_frame_change();
    test_frames("new_frame", 4 * RD);
    set_dig(4'd10, 4'd2, 4'd3, 4'd4);
    test_frames("invalid_digit", 8 * RD);
    adj = 1'b1;
    sel = 1'b1;
    test_frames("blink_sec", 8 * RD);
    sel = 1'b0;
    test_frames("blink_min", 8 * RD);
    adj = 1'b0;
    test_frames("blink_off", 4 * RD);
    set_dig(4'd0, 4'd5, 4'd0, 4'd9);
    test_frames("leading_zero", 8 * RD);
    set_dig(4'd1, 4'd2, 4'd3, 4'd4);
    test_mid_reset();
    test_frames("after_reset", 8 * RD);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
